// File: rtl/urv_dm_wb_bridge.sv
// uRV data-memory port to Wishbone B4 pipelined master bridge (single outstanding transfer).
// Define URV_DM_WB_TIMEOUT_EN to force-terminate a stuck transfer as a bus error.
module urv_dm_wb_bridge #(
  parameter int g_timeout_cycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_s_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic        cpu_load_i,
  input  logic        cpu_store_i,
  output logic        cpu_ready_o,
  output logic [31:0] cpu_data_l_o,
  output logic        cpu_load_done_o,
  output logic        cpu_store_done_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i,
  output logic        bus_err_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  if ((g_timeout_cycles < 2) || (g_timeout_cycles > 65535)) begin : g_bad_timeout
    $error("g_timeout_cycles out of range 2..65535");
  end

  logic [1:0]  r_state;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_we;
  logic [31:0] r_ldat;
  logic        r_ldone;
  logic        r_sdone;
  logic        r_err;

  logic w_accept;
  logic w_live;
  logic w_ack;
  logic w_berr;
  logic w_tmo;
  logic w_fail;
  logic w_done;

  assign w_accept = (r_state == ST_IDLE) && (cpu_load_i || cpu_store_i);
  // Slave responses only count once the strobe has been taken (or is being taken now).
  assign w_live   = (r_state == ST_WAIT) || ((r_state == ST_REQ) && !wb_stall_i);
  assign w_ack    = w_live && wb_ack_i && !wb_err_i;
  assign w_berr   = w_live && wb_err_i;
  assign w_fail   = w_berr || w_tmo;
  assign w_done   = w_ack || w_fail;

`ifdef URV_DM_WB_TIMEOUT_EN
  localparam logic [15:0] LP_TMO_LAST = 16'(g_timeout_cycles - 1);
  logic [15:0] r_tmo_cnt;

  // Counter holds the number of bus cycles already spent; the g-th cycle terminates.
  assign w_tmo = (r_state != ST_IDLE) && (r_tmo_cnt == LP_TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tmo_cnt <= '0;
    end else if (w_accept) begin
      r_tmo_cnt <= '0;
    end else if (r_state != ST_IDLE) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_adr   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_ldat  <= '0;
      r_ldone <= 1'b0;
      r_sdone <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ldone <= 1'b0;
      r_sdone <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we    <= cpu_store_i;
            r_adr   <= cpu_addr_i;
            r_dat   <= cpu_data_s_i;
            r_sel   <= cpu_sel_i;
            r_state <= ST_REQ;
          end
        end
        ST_REQ, ST_WAIT: begin
          if (w_done) begin
            r_state <= ST_IDLE;
            r_err   <= w_fail;
            if (r_we) r_sdone <= 1'b1;
            else      r_ldone <= 1'b1;
            if (w_fail)     r_ldat <= '0;
            else if (!r_we) r_ldat <= wb_dat_i;
          end else if ((r_state == ST_REQ) && !wb_stall_i) begin
            r_state <= ST_WAIT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_ready_o      = (r_state == ST_IDLE);
  assign cpu_data_l_o     = r_ldat;
  assign cpu_load_done_o  = r_ldone;
  assign cpu_store_done_o = r_sdone;
  assign bus_err_o        = r_err;
  assign wb_cyc_o         = (r_state != ST_IDLE);
  assign wb_stb_o         = (r_state == ST_REQ);
  assign wb_we_o          = r_we;
  assign wb_adr_o         = r_adr & 32'hFFFF_FFFC;
  assign wb_sel_o         = r_sel;
  assign wb_dat_o         = r_dat;

endmodule

// File: doc/urv_dm_wb_bridge.md
URV_DM_WB_BRIDGE -- requirements
Module: urv_dm_wb_bridge

Interface
REQ-001 SHALL have parameter g_timeout_cycles, default 1024, the number of bus-wait cycles before forced termination (range 2..65535; used only when the Configuration macro is defined).
REQ-002 SHALL have ports, clock and reset first:
 clk_i  in  1  sole clock; all state changes on the rising edge.
 rst_n_i  in  1  reset; asynchronous and active-low.
 cpu_addr_i  in  32  CPU data address; bits [1:0] ignored.
 cpu_data_s_i  in  32  CPU store data.
 cpu_sel_i  in  4  CPU byte-lane select.
 cpu_load_i  in  1  one-cycle load request.
 cpu_store_i  in  1  one-cycle store request.
 cpu_ready_o  out  1  bridge can accept a request this cycle.
 cpu_data_l_o  out  32  load data; valid while cpu_load_done_o=1.
 cpu_load_done_o  out  1  one-cycle load completion pulse.
 cpu_store_done_o  out  1  one-cycle store completion pulse.
 wb_cyc_o  out  1  Wishbone B4 pipelined cycle.
 wb_stb_o  out  1  strobe.
 wb_we_o  out  1  write enable.
 wb_adr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
 wb_sel_o  out  4  byte select.
 wb_dat_o  out  32  write data.
 wb_dat_i  in  32  read data.
 wb_ack_i  in  1  acknowledge.
 wb_err_i  in  1  bus error.
 wb_stall_i  in  1  slave stall.
 bus_err_o  out  1  one-cycle pulse when a transfer ends with error or timeout.

Function
REQ-003 SHALL implement a three-state FSM: IDLE, REQ (strobe pending) and WAIT (strobe accepted, awaiting ack).
REQ-004 SHALL drive cpu_ready_o=1 only in IDLE.
REQ-005 SHALL sample a request in IDLE when cpu_load_i or cpu_store_i is 1, register addr/data/sel/we, and enter REQ on the next edge.
REQ-006 SHALL give store priority if cpu_load_i and cpu_store_i are both 1 in the same cycle.
REQ-007 SHALL ignore cpu_load_i and cpu_store_i outside IDLE, with no queuing.
REQ-008 SHALL hold wb_cyc_o=wb_stb_o=1 with stable adr/sel/we/dat in REQ, and SHALL go to WAIT on the first cycle where wb_stall_i=0.
REQ-009 SHALL hold wb_cyc_o=1 and wb_stb_o=0 in WAIT.
REQ-010 SHALL treat wb_ack_i or wb_err_i as termination in REQ (when wb_stall_i=0) or in WAIT: next edge returns to IDLE, drops wb_cyc_o, and pulses the matching done output for exactly one cycle.
REQ-011 SHALL register cpu_data_l_o from wb_dat_i on ack, and SHALL set it to 0x00000000 on error termination.
REQ-012 SHALL pulse bus_err_o together with the done pulse when wb_err_i terminated the transfer; if ack and err are both 1, err wins.
REQ-013 SHALL have minimum latency with zero stall: request at cycle N, stb at N+1, ack at N+2, done plus ready at N+3; a new request SHALL be accepted in that same cycle N+3.
REQ-014 SHALL ignore wb_ack_i and wb_err_i in IDLE.

Reset
REQ-015 SHALL, while rst_n_i=0, force within the same cycle (asynchronously): FSM=IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_dat_o=0, wb_sel_o=0, cpu_data_l_o=0, both done outputs=0, bus_err_o=0, timeout counter=0, cpu_ready_o=1.
REQ-016 SHALL abandon a transfer in flight when reset is asserted, with no done pulse; acks arriving after release SHALL be ignored per REQ-014.

Configuration
REQ-017 SHALL, when URV_DM_WB_TIMEOUT_EN is defined, count cycles spent in REQ+WAIT (clear on entry to REQ) and, on reaching g_timeout_cycles without termination, end the transfer as an error per REQ-010/011/012.
REQ-018 SHALL, when URV_DM_WB_TIMEOUT_EN is undefined, contain no counter and wait indefinitely in REQ/WAIT.

Verification
REQ-019 Load at 0x00000104, sel=F, no stall, ack next cycle with dat=0xCAFEF00D -> cpu_load_done_o pulse with cpu_data_l_o=0xCAFEF00D at N+3, wb_adr_o=0x00000104.
REQ-020 Store 0x12345678 to 0x00000203, sel=4'b0100, stall held 3 cycles -> stb held 4 cycles, wb_adr_o=0x00000200, we=1, one cpu_store_done_o pulse.
REQ-021 Load terminated by wb_err_i -> cpu_load_done_o and bus_err_o pulse together, cpu_data_l_o=0x00000000.
REQ-022 Load and store both asserted, followed by a second request while busy -> store executes; second request ignored; exactly one done pulse.
REQ-023 rst_n_i low while in WAIT, then ack after release -> cyc drops immediately, no done pulse, cpu_ready_o=1.
REQ-024 With URV_DM_WB_TIMEOUT_EN and g_timeout_cycles=16, no ack -> error termination after 16 cycles; without the macro -> wb_cyc_o stays 1 for at least 100 cycles.
